// File: rtl/pixel_port_arbiter_pkg.sv
// pixel_pkg: shared widths, requester indices, FSM encoding and helpers for the pixel port arbiter
// No ports; imported by the interface, arb_pick and pixel_port_arbiter.
package pixel_pkg;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int N_REQ = 3;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 15;
  localparam int REQ_CLEAR = 0;
  localparam int REQ_BG = 1;
  localparam int REQ_SPRITE = 2;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  function automatic logic [1:0] onehot_idx(input logic [N_REQ-1:0] g);
    return g[REQ_SPRITE] ? 2'd2 : g[REQ_BG] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pixel_port_arbiter_if.sv
// pixel_port_arbiter_if: requester pixel bus plus VGA adapter outputs of the arbiter
// master: requesters/VGA side (drives req, pix_*; sees gnt, vga_*, timeout_err)
// slave:  arbiter side (sees req, pix_*; drives gnt, vga_*, timeout_err)
interface pixel_port_arbiter_if;
  import pixel_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] pix_valid;
  logic [N_REQ-1:0] pix_last;
  logic [N_REQ*X_W-1:0] pix_x;
  logic [N_REQ*Y_W-1:0] pix_y;
  logic [N_REQ*C_W-1:0] pix_colour;
  logic [N_REQ-1:0] gnt;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic vga_plot;
  logic timeout_err;
  modport master (
    output req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    input gnt, vga_x, vga_y, vga_colour, vga_plot, timeout_err
  );
  modport slave (
    input req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
    output gnt, vga_x, vga_y, vga_colour, vga_plot, timeout_err
  );
endinterface

// File: rtl/pixel_port_arbiter_arb_pick.sv
// arb_pick: combinational winner select, clear engine first, then round-robin bg/sprite
// req_i: request vector; rr_i: 0 prefers bg tiler, 1 prefers sprite; win_o: one-hot-or-zero winner
module arb_pick
  import pixel_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             rr_i,
  output logic [N_REQ-1:0] win_o
);
  assign win_o = req_i[REQ_CLEAR] ? 3'b001 :
                 (req_i[REQ_BG] && (!rr_i || !req_i[REQ_SPRITE])) ? 3'b010 :
                 req_i[REQ_SPRITE] ? 3'b100 : 3'b000;
endmodule

// File: rtl/pixel_port_arbiter.sv
// pixel_port_arbiter: grants one of three pixel producers a burst and forwards its pixels to the VGA adapter
// clk: 50 MHz clock; reset: synchronous active-low
// bus (slave): req/pix_valid/pix_last/pix_x/pix_y/pix_colour in; gnt, vga_x/y/colour/plot, timeout_err out
module pixel_port_arbiter
  import pixel_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int TIMEOUT = 1023
) (
  input logic                 clk,
  input logic                 reset,
  pixel_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1) < 10 ? 10 : $clog2(TIMEOUT + 1);
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(V_RES);
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, win;
  logic rr_q, rr_d, err_q, err_d, plot_q, plot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d, gx;
  logic [Y_W-1:0] y_q, y_d, gy;
  logic [C_W-1:0] c_q, c_d, gc;
  logic acc, fin, drop, tmo;
  int sel;
  arb_pick u_pick (.req_i(bus.req), .rr_i(rr_q), .win_o(win));
  assign sel = int'(onehot_idx(gnt_q));
  assign gx = bus.pix_x[sel*X_W +: X_W];
  assign gy = bus.pix_y[sel*Y_W +: Y_W];
  assign gc = bus.pix_colour[sel*C_W +: C_W];
  // a pixel counts only from the granted requester while it still requests
  assign acc = |(gnt_q & bus.pix_valid & bus.req);
  assign fin = |(gnt_q & bus.pix_valid & bus.pix_last & bus.req);
  assign drop = ~|(gnt_q & bus.req);
  // release on the edge where the idle count would reach TIMEOUT
  assign tmo = !acc && cnt_q == CNT_END;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      plot_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      plot_q <= plot_d;
      x_q <= x_d;
      y_q <= y_d;
      c_q <= c_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    err_d = err_q;
    cnt_d = acc ? '0 : cnt_q + 1'b1;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (|bus.req) begin
        state_d = BURST;
        gnt_d = win;
      end
    end else if (fin || drop || tmo) begin
      state_d = IDLE;
      gnt_d = '0;
      cnt_d = '0;
      // a finished bg burst hands preference to the sprite and vice versa
      rr_d = gnt_q[REQ_CLEAR] ? rr_q : gnt_q[REQ_BG];
      err_d = err_q | (tmo & ~drop);
    end
  end
  always_comb begin
    x_d = acc ? gx : x_q;
    y_d = acc ? gy : y_q;
    c_d = acc ? gc : c_q;
    plot_d = acc && ({1'b0, gx} < X_LIM) && ({1'b0, gy} < Y_LIM);
  end
  assign bus.gnt = gnt_q;
  assign bus.vga_x = x_q;
  assign bus.vga_y = y_q;
  assign bus.vga_colour = c_q;
  assign bus.vga_plot = plot_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_pixel_port_arbiter.sv
// tb_pixel_port_arbiter: directed scenarios plus randomized requesters against a rule-level model
module tb_pixel_port_arbiter;
  import pixel_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  pixel_port_arbiter_if bus();
  pixel_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;

  task automatic drive_pix(input int n, input bit v, input bit l, input logic [8:0] x,
                           input logic [7:0] y, input logic [14:0] c);
    bus.pix_valid[n] = v;
    bus.pix_last[n] = l;
    bus.pix_x[n*9 +: 9] = x;
    bus.pix_y[n*8 +: 8] = y;
    bus.pix_colour[n*15 +: 15] = c;
  endtask

  task automatic idle_inputs();
    bus.req = '0;
    for (int n = 0; n < 3; n++) drive_pix(n, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 3'b111;
    for (int n = 0; n < 3; n++) drive_pix(n, 1'b1, 1'b0, 9'(n + 3), 8'(n + 4), 15'(n + 5));
    repeat (3) @(negedge clk);
    n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
    n_tests++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 32'd0) begin n_fail++; $display("FAIL reset_vga: got %h/%h/%h want 0/0/0", bus.vga_x, bus.vga_y, bus.vga_colour); end
    n_tests++; if (bus.vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b want 0", bus.vga_plot); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.timeout_err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 3'b110;
    @(negedge clk);
    n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL rr_first: got %b want 010", bus.gnt); end
    drive_pix(1, 1'b1, 1'b0, 9'd10, 8'd20, 15'h1234);
    @(negedge clk);
    n_tests++; if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 9'd10, 8'd20, 15'h1234}) begin n_fail++; $display("FAIL rr_pix1: got %b %0d %0d %h want 1 10 20 1234", bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour); end
    drive_pix(1, 1'b1, 1'b1, 9'd11, 8'd21, 15'h0abc);
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {3'b000, 1'b1, 9'd11, 8'd21, 15'h0abc}) begin n_fail++; $display("FAIL rr_last: got gnt=%b plot=%b %0d %0d %h want 000 1 11 21 0abc", bus.gnt, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour); end
    drive_pix(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.vga_plot} !== {3'b100, 1'b0}) begin n_fail++; $display("FAIL rr_toggle: got gnt=%b plot=%b want 100 0", bus.gnt, bus.vga_plot); end
    drive_pix(2, 1'b1, 1'b1, 9'd1, 8'd2, 15'd3);
    @(negedge clk);
    n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL rr_sprite_end: got %b want 000", bus.gnt); end
    drive_pix(2, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL rr_back: got %b want 010", bus.gnt); end
  endtask

  task automatic test_no_preempt();
    int plots;
    plots = 0;
    do_reset();
    bus.req = 3'b100;
    @(negedge clk);
    n_tests++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL np_grant: got %b want 100", bus.gnt); end
    bus.req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      drive_pix(2, 1'b1, i == 3, 9'(30 + i), 8'(40 + i), 15'(100 * i));
      @(negedge clk);
      if (bus.vga_plot === 1'b1) plots++;
      if (i < 3) begin
        n_tests++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL np_hold%0d: got %b want 100", i, bus.gnt); end
      end
    end
    n_tests++; if ({bus.gnt, bus.vga_x, bus.vga_colour} !== {3'b000, 9'd33, 15'd300}) begin n_fail++; $display("FAIL np_dead: got gnt=%b x=%0d c=%0d want 000 33 300", bus.gnt, bus.vga_x, bus.vga_colour); end
    drive_pix(2, 1'b0, 1'b0, '0, '0, '0);
    bus.req = 3'b001;
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.vga_plot} !== {3'b001, 1'b0}) begin n_fail++; $display("FAIL np_clear_wins: got gnt=%b plot=%b want 001 0", bus.gnt, bus.vga_plot); end
    n_tests++; if (plots != 4) begin n_fail++; $display("FAIL np_plots: got %0d want 4", plots); end
  endtask

  task automatic test_bounds();
    do_reset();
    bus.req = 3'b010;
    @(negedge clk);
    drive_pix(1, 1'b1, 1'b0, 9'd319, 8'd239, 15'h7fff);
    @(negedge clk);
    n_tests++; if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 9'd319, 8'd239, 15'h7fff}) begin n_fail++; $display("FAIL bnd_corner: got %b %0d %0d %h want 1 319 239 7fff", bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour); end
    drive_pix(1, 1'b1, 1'b0, 9'd320, 8'd10, 15'h0001);
    @(negedge clk);
    n_tests++; if ({bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b0, 9'd320, 8'd10}) begin n_fail++; $display("FAIL bnd_x: got %b %0d %0d want 0 320 10", bus.vga_plot, bus.vga_x, bus.vga_y); end
    drive_pix(1, 1'b1, 1'b0, 9'd5, 8'd240, 15'h0002);
    @(negedge clk);
    n_tests++; if ({bus.vga_plot, bus.vga_x, bus.vga_y} !== {1'b0, 9'd5, 8'd240}) begin n_fail++; $display("FAIL bnd_y: got %b %0d %0d want 0 5 240", bus.vga_plot, bus.vga_x, bus.vga_y); end
    drive_pix(1, 1'b0, 1'b0, '0, '0, '0);
    drive_pix(2, 1'b1, 1'b1, 9'd100, 8'd100, 15'h1111);
    drive_pix(0, 1'b1, 1'b1, 9'd50, 8'd50, 15'h2222);
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.vga_plot, bus.vga_x} !== {3'b010, 1'b0, 9'd5}) begin n_fail++; $display("FAIL bnd_ignore: got gnt=%b plot=%b x=%0d want 010 0 5", bus.gnt, bus.vga_plot, bus.vga_x); end
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    do_reset();
    bus.req = 3'b110;
    @(negedge clk);
    while (bus.gnt === 3'b010 && held < 1100) begin
      held++;
      @(negedge clk);
    end
    n_tests++; if (held != 1023) begin n_fail++; $display("FAIL to_held: got %0d cycles want 1023", held); end
    n_tests++; if ({bus.gnt, bus.timeout_err} !== {3'b000, 1'b1}) begin n_fail++; $display("FAIL to_release: got gnt=%b err=%b want 000 1", bus.gnt, bus.timeout_err); end
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.timeout_err} !== {3'b100, 1'b1}) begin n_fail++; $display("FAIL to_next: got gnt=%b err=%b want 100 1", bus.gnt, bus.timeout_err); end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      drive_pix(2, 1'b1, 1'b0, 9'(60 + i), 8'(70 + i), 15'h3000);
      @(negedge clk);
    end
    n_tests++; if ({bus.vga_plot, bus.vga_x} !== {1'b1, 9'd62}) begin n_fail++; $display("FAIL mid_pix3: got %b %0d want 1 62", bus.vga_plot, bus.vga_x); end
    reset = 1'b0;
    drive_pix(2, 1'b1, 1'b0, 9'd90, 8'd91, 15'h0fff);
    @(negedge clk);
    n_tests++; if ({bus.gnt, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.timeout_err} !== 37'd0) begin n_fail++; $display("FAIL mid_reset: got gnt=%b %h %h %h plot=%b err=%b want all 0", bus.gnt, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.timeout_err); end
    reset = 1'b1;
    drive_pix(2, 1'b0, 1'b0, '0, '0, '0);
    bus.req = 3'b110;
    do begin
      @(negedge clk);
      k++;
    end while (bus.gnt === 3'b000 && k < 4);
    n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL mid_first_grant: got %b want 010", bus.gnt); end
  endtask

  task automatic test_random();
    logic [2:0] g, g_prev, req_prev, want, exp_g;
    logic [8:0] ex, x;
    logic [7:0] ey, y;
    logic [14:0] ec, c;
    int rem[3];
    int last_srv, gi;
    bit exp_v, exp_plot, end_exp;
    do_reset();
    g_prev = '0; req_prev = '0; want = '0; last_srv = 2;
    exp_v = 0; exp_plot = 0; end_exp = 0; ex = '0; ey = '0; ec = '0;
    rem = '{0, 0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      g = bus.gnt;
      n_tests++; if ($countones(g) > 1) begin n_fail++; $display("FAIL rnd_onehot c%0d: got %b want at most one bit", cyc, g); end
      n_tests++; if (bus.vga_plot !== (exp_v & exp_plot)) begin n_fail++; $display("FAIL rnd_plot c%0d: got %b want %b", cyc, bus.vga_plot, exp_v & exp_plot); end
      if (exp_v) begin
        n_tests++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== {ex, ey, ec}) begin n_fail++; $display("FAIL rnd_pix c%0d: got %0d %0d %h want %0d %0d %h", cyc, bus.vga_x, bus.vga_y, bus.vga_colour, ex, ey, ec); end
      end
      if (g_prev != 3'b000) exp_g = end_exp ? 3'b000 : g_prev;
      else exp_g = req_prev[0] ? 3'b001 :
                   (req_prev[1] && req_prev[2]) ? (last_srv == 1 ? 3'b100 : 3'b010) :
                   req_prev[1] ? 3'b010 : req_prev[2] ? 3'b100 : 3'b000;
      n_tests++; if (g !== exp_g) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, g, exp_g); end
      if (g_prev != 3'b000 && exp_g == 3'b000) last_srv = g_prev[1] ? 1 : g_prev[2] ? 2 : last_srv;
      exp_v = 0;
      end_exp = 0;
      for (int n = 0; n < 3; n++) begin
        if (want[n] && rem[n] == 0) want[n] = 1'b0;
        else if (!want[n] && $urandom_range(0, 3) == 0) begin
          want[n] = 1'b1;
          rem[n] = $urandom_range(1, 5);
        end
        drive_pix(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), 15'($urandom));
      end
      if (g != 3'b000) begin
        gi = g[2] ? 2 : g[1] ? 1 : 0;
        if (rem[gi] > 0 && $urandom_range(0, 3) != 0) begin
          rem[gi]--;
          x = 9'($urandom_range(0, 399));
          y = 8'($urandom_range(0, 255));
          c = 15'($urandom);
          drive_pix(gi, 1'b1, rem[gi] == 0, x, y, c);
          exp_v = 1;
          exp_plot = (x < 9'd320) && (y < 8'd240);
          ex = x; ey = y; ec = c;
          end_exp = rem[gi] == 0;
        end else drive_pix(gi, 1'b0, 1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), 15'($urandom));
      end
      bus.req = want;
      req_prev = want;
      g_prev = g;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_preempt();
    test_bounds();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
